bit_rate_scheduler: RTL and testbench

Time-shares one bit-rate measurement engine (window tick counter plus beat counter) among NUM_CH stream channels. Sequences programmable measurement windows round-robin over the enabled channels, in one-shot sweep or continuous mode. Each window result is delivered through a valid/ready handshake. Sits between the stream datapaths and the status/CSR logic that collects throughput figures.

---
 rtl/bit_rate_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_bit_rate_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_rate_scheduler.sv
// bit_rate_scheduler: shares one bit-rate measurement engine round-robin
// across NUM_CH stream channels. Each window of win_ticks cycles is followed
// by a result. The result is delivered over a valid/ready handshake.
// Optional build macro BIT_RATE_SCHED_PEAK_EN adds the per-channel peak output
// res_peak_o.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a legal start; config is latched on start
// SELECT  | picks the channel for the next window, clears the counters
// MEASURE | counts beats on ch_sel_o for win ticks
// REPORT  | holds the result until it is accepted
module bit_rate_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int WIN_WIDTH  = 32,
  parameter int RES_WIDTH  = 32
) (
  input  logic                      clk_i,
  input  logic                      s_rst_i,
  input  logic                      start_i,
  input  logic                      stop_i,
  input  logic                      continuous_i,
  input  logic [WIN_WIDTH-1:0]      win_ticks_i,
  input  logic [NUM_CH-1:0]         ch_en_i,
  input  logic [NUM_CH-1:0]         data_valid_i,
  output logic                      busy_o,
  output logic [$clog2(NUM_CH)-1:0] ch_sel_o,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [$clog2(NUM_CH)-1:0] res_ch_o,
  output logic [RES_WIDTH-1:0]      res_bits_o,
  output logic                      res_ovf_o,
`ifdef BIT_RATE_SCHED_PEAK_EN
  output logic [RES_WIDTH-1:0]      res_peak_o,
`endif
  output logic                      err_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int SHIFT = $clog2(DATA_WIDTH);
  localparam int EXT_W = RES_WIDTH + SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_MEASURE, S_REPORT} state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_sel_q, ch_sel_d;
  logic [CH_W-1:0]       res_ch_q, res_ch_d;
  logic [RES_WIDTH-1:0]  res_bits_q, res_bits_d;
  logic                  res_ovf_q, res_ovf_d;
  logic                  err_q, err_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  cont_q, cont_d;
  logic                  wrap_q, wrap_d;
  logic [WIN_WIDTH-1:0]  win_q, win_d;
  logic [NUM_CH-1:0]     ch_en_q, ch_en_d;
  logic [WIN_WIDTH-1:0]  tick_q, tick_d;
  logic [RES_WIDTH-1:0]  beat_q, beat_d;
  logic                  sat_q, sat_d;

  logic                  start_ok, win_end;
  logic                  beat_inc;
  logic [RES_WIDTH-1:0]  beat_next;
  logic                  sat_next;
  logic [EXT_W-1:0]      shifted;
  logic [RES_WIDTH-1:0]  res_bits_calc;
  logic                  res_ovf_calc;
  logic [CH_W-1:0]       lowest_ch, higher_ch;
  logic                  higher_found, lowest_found;

  assign start_ok = (state_q == S_IDLE) && start_i && !stop_i &&
                    (win_ticks_i != '0) && (ch_en_i != '0);
  assign win_end  = (state_q == S_MEASURE) && !stop_i && (tick_q == win_q - 1'b1);

  // Channel search: lowest enabled, and the next enabled above the last reported.
  always_comb begin
    lowest_ch    = '0;
    higher_ch    = '0;
    lowest_found = 1'b0;
    higher_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_en_q[i] && !lowest_found) begin
        lowest_ch    = CH_W'(i);
        lowest_found = 1'b1;
      end
      if (ch_en_q[i] && !higher_found && (i > int'(res_ch_q))) begin
        higher_ch    = CH_W'(i);
        higher_found = 1'b1;
      end
    end
  end

  // Beat counting with saturation and result scaling/overflow detection.
  always_comb begin
    beat_inc      = (state_q == S_MEASURE) && data_valid_i[ch_sel_q];
    beat_next     = (beat_inc && !(&beat_q)) ? beat_q + 1'b1 : beat_q;
    sat_next      = sat_q | (beat_inc & (&beat_q));
    shifted       = EXT_W'(beat_next) << SHIFT;
    res_ovf_calc  = sat_next | ((shifted >> RES_WIDTH) != '0);
    res_bits_calc = res_ovf_calc ? '1 : shifted[RES_WIDTH-1:0];
  end

  // Next-state and datapath update for the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    ch_sel_d    = ch_sel_q;
    res_ch_d    = res_ch_q;
    res_bits_d  = res_bits_q;
    res_ovf_d   = res_ovf_q;
    err_d       = 1'b0;
    stop_pend_d = stop_pend_q;
    cont_d      = cont_q;
    wrap_d      = wrap_q;
    win_d       = win_q;
    ch_en_d     = ch_en_q;
    tick_d      = tick_q;
    beat_d      = beat_q;
    sat_d       = sat_q;
    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start_ok) begin
          win_d   = win_ticks_i;
          ch_en_d = ch_en_i;
          cont_d  = continuous_i;
          wrap_d  = 1'b1;
          state_d = S_SELECT;
        end else if (start_i && !stop_i) begin
          err_d = 1'b1;
        end
      end
      S_SELECT: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else begin
          ch_sel_d = wrap_q ? lowest_ch : higher_ch;
          wrap_d   = 1'b0;
          tick_d   = '0;
          beat_d   = '0;
          sat_d    = 1'b0;
          state_d  = S_MEASURE;
        end
      end
      S_MEASURE: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else begin
          beat_d = beat_next;
          sat_d  = sat_next;
          tick_d = tick_q + 1'b1;
          if (win_end) begin
            res_bits_d = res_bits_calc;
            res_ovf_d  = res_ovf_calc;
            res_ch_d   = ch_sel_q;
            state_d    = S_REPORT;
          end
        end
      end
      S_REPORT: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (res_ready_i) begin
          if (stop_pend_q || stop_i) begin
            stop_pend_d = 1'b0;
            state_d     = S_IDLE;
          end else if (!higher_found) begin
            wrap_d  = cont_q;
            state_d = cont_q ? S_SELECT : S_IDLE;
          end else begin
            state_d = S_SELECT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state_q     <= S_IDLE;
      ch_sel_q    <= '0;
      res_ch_q    <= '0;
      res_bits_q  <= '0;
      res_ovf_q   <= 1'b0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      cont_q      <= 1'b0;
      wrap_q      <= 1'b0;
      win_q       <= '0;
      ch_en_q     <= '0;
      tick_q      <= '0;
      beat_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_sel_q    <= ch_sel_d;
      res_ch_q    <= res_ch_d;
      res_bits_q  <= res_bits_d;
      res_ovf_q   <= res_ovf_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
      cont_q      <= cont_d;
      wrap_q      <= wrap_d;
      win_q       <= win_d;
      ch_en_q     <= ch_en_d;
      tick_q      <= tick_d;
      beat_q      <= beat_d;
      sat_q       <= sat_d;
    end
  end

`ifdef BIT_RATE_SCHED_PEAK_EN
  logic [RES_WIDTH-1:0] peak_q [NUM_CH];
  logic [RES_WIDTH-1:0] peak_d [NUM_CH];

  // Peak tracking: cleared on accepted start, updated with each new result.
  always_comb begin
    peak_d = peak_q;
    if (start_ok) begin
      for (int i = 0; i < NUM_CH; i++) peak_d[i] = '0;
    end else if (win_end && (res_bits_calc > peak_q[ch_sel_q])) begin
      peak_d[ch_sel_q] = res_bits_calc;
    end
  end

  // Peak registers.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      for (int i = 0; i < NUM_CH; i++) peak_q[i] <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign res_peak_o = peak_q[res_ch_q];
`endif

  assign busy_o      = (state_q != S_IDLE);
  assign res_valid_o = (state_q == S_REPORT);
  assign ch_sel_o    = ch_sel_q;
  assign res_ch_o    = res_ch_q;
  assign res_bits_o  = res_bits_q;
  assign res_ovf_o   = res_ovf_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_bit_rate_scheduler.sv
// Testbench for bit_rate_scheduler: scoreboard of expected results checked at
// each handshake, plus directed checks for stop, error, backpressure and overflow.
module tb_bit_rate_scheduler;

  localparam int NUM_CH = 4;

  logic        clk_i = 1'b0;
  logic        s_rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        continuous_i = 1'b0;
  logic [31:0] win_ticks_i = '0;
  logic [3:0]  ch_en_i = '0;
  logic [3:0]  dv_base = '0;
  logic        alt_en = 1'b0;
  logic        phase = 1'b0;
  logic [3:0]  data_valid_i;
  logic        res_ready_i = 1'b1;

  logic        busy_o, res_valid_o, res_ovf_o, err_o;
  logic [1:0]  ch_sel_o, res_ch_o;
  logic [31:0] res_bits_o;

  logic        o_busy, o_res_valid, o_res_ovf, o_err;
  logic [1:0]  o_ch_sel, o_res_ch;
  logic [7:0]  o_res_bits;

`ifdef BIT_RATE_SCHED_PEAK_EN
  logic [31:0] res_peak;
  logic [7:0]  o_res_peak;
`endif

  assign data_valid_i = dv_base | {1'b0, alt_en & phase, 2'b00};

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) begin
    cyc   <= cyc + 1;
    phase <= ~phase;
  end

  bit_rate_scheduler #(.NUM_CH(4), .DATA_WIDTH(32), .WIN_WIDTH(32), .RES_WIDTH(32)) dut (
    .clk_i(clk_i), .s_rst_i(s_rst_i), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .win_ticks_i(win_ticks_i), .ch_en_i(ch_en_i),
    .data_valid_i(data_valid_i), .busy_o(busy_o), .ch_sel_o(ch_sel_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_ch_o(res_ch_o),
    .res_bits_o(res_bits_o), .res_ovf_o(res_ovf_o),
`ifdef BIT_RATE_SCHED_PEAK_EN
    .res_peak_o(res_peak),
`endif
    .err_o(err_o)
  );

  bit_rate_scheduler #(.NUM_CH(4), .DATA_WIDTH(32), .WIN_WIDTH(32), .RES_WIDTH(8)) dut_ovf (
    .clk_i(clk_i), .s_rst_i(s_rst_i), .start_i(start_i), .stop_i(stop_i),
    .continuous_i(continuous_i), .win_ticks_i(win_ticks_i), .ch_en_i(ch_en_i),
    .data_valid_i(data_valid_i), .busy_o(o_busy), .ch_sel_o(o_ch_sel),
    .res_valid_o(o_res_valid), .res_ready_i(res_ready_i), .res_ch_o(o_res_ch),
    .res_bits_o(o_res_bits), .res_ovf_o(o_res_ovf),
`ifdef BIT_RATE_SCHED_PEAK_EN
    .res_peak_o(o_res_peak),
`endif
    .err_o(o_err)
  );

  typedef struct {
    logic [1:0]  ch;
    logic [31:0] bits;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   spacing_en = 1'b0;
  bit   have_last  = 1'b0;
  int   last_hs    = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic push_exp(input logic [1:0] ch, input logic [31:0] bits);
    exp_t e;
    e.ch = ch; e.bits = bits; e.ovf = 1'b0;
    exp_q.push_back(e);
  endtask

  // Scoreboard: compare every accepted result with the oldest expectation.
  always @(negedge clk_i) begin
    if (!s_rst_i && res_valid_o && res_ready_i) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("res_ch", {30'd0, res_ch_o}, {30'd0, e.ch});
        check_eq("res_bits", res_bits_o, e.bits);
        check_eq("res_ovf", {31'd0, res_ovf_o}, {31'd0, e.ovf});
        if (spacing_en && have_last) check_eq("spacing", cyc - last_hs, 6);
        last_hs   = cyc;
        have_last = 1'b1;
      end
    end
  end

  task automatic start_run(input int win, input logic [3:0] en, input logic cont);
    @(posedge clk_i); #1;
    win_ticks_i  = win;
    ch_en_i      = en;
    continuous_i = cont;
    start_i      = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (busy_o && n < budget);
    check_eq("idle_reached", {31'd0, busy_o}, 32'd0);
    check_eq("sb_empty", exp_q.size(), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!res_valid_o && n < budget);
    check_eq("valid_reached", {31'd0, res_valid_o}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 s_rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_busy", {31'd0, busy_o}, 0);
    check_eq("rst_valid", {31'd0, res_valid_o}, 0);
    check_eq("rst_err", {31'd0, err_o}, 0);
    check_eq("rst_ch_sel", {30'd0, ch_sel_o}, 0);
    check_eq("rst_res_ch", {30'd0, res_ch_o}, 0);
    check_eq("rst_bits", res_bits_o, 0);
    check_eq("rst_ovf", {31'd0, res_ovf_o}, 0);

    // One-shot sweep over ch0 (every cycle) and ch2 (alternate cycles).
    dv_base = 4'b0001; alt_en = 1'b1; res_ready_i = 1'b1;
    push_exp(2'd0, 32'd320);
    push_exp(2'd2, 32'd160);
    start_run(10, 4'b0101, 1'b0);
    wait_idle(100);
    alt_en = 1'b0;

    // Continuous mode over ch1/ch3, results spaced win+2.
    dv_base = 4'b1010; have_last = 1'b0; spacing_en = 1'b1;
    push_exp(2'd1, 32'd128); push_exp(2'd3, 32'd128);
    push_exp(2'd1, 32'd128); push_exp(2'd3, 32'd128);
    start_run(4, 4'b1010, 1'b1);
    begin
      int n = 0;
      do begin
        @(posedge clk_i);
        n++;
      end while (exp_q.size() != 0 && n < 100);
    end
    #1 stop_i = 1'b1;
    @(posedge clk_i); #1 stop_i = 1'b0;
    spacing_en = 1'b0;
    @(negedge clk_i);
    check_eq("cont_stop_idle", {31'd0, busy_o}, 0);
    check_eq("cont_sb_empty", exp_q.size(), 0);

    // Backpressure: result held stable, beats during REPORT ignored.
    dv_base = 4'b0011; res_ready_i = 1'b0;
    push_exp(2'd0, 32'd256); push_exp(2'd1, 32'd256);
    start_run(8, 4'b0011, 1'b0);
    wait_valid(50);
    for (int i = 0; i < 20; i++) begin
      check_eq("bp_valid", {31'd0, res_valid_o}, 1);
      check_eq("bp_bits", res_bits_o, 256);
      check_eq("bp_ch", {30'd0, res_ch_o}, 0);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1 res_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("bp_drop_valid", {31'd0, res_valid_o}, 0);
    check_eq("bp_still_busy", {31'd0, busy_o}, 1);
    wait_idle(50);

    // Stop during MEASURE tick 3: abort without result.
    dv_base = 4'b0001;
    start_run(10, 4'b0001, 1'b0);
    repeat (4) @(posedge clk_i);
    #1 stop_i = 1'b1;
    @(posedge clk_i); #1 stop_i = 1'b0;
    @(negedge clk_i);
    check_eq("stop_meas_idle", {31'd0, busy_o}, 0);
    check_eq("stop_meas_novalid", {31'd0, res_valid_o}, 0);
    repeat (12) @(negedge clk_i);
    check_eq("stop_meas_stays_idle", {31'd0, busy_o}, 0);

    // Stop during REPORT: current result delivered, then IDLE.
    dv_base = 4'b0011; res_ready_i = 1'b0;
    push_exp(2'd0, 32'd128);
    start_run(4, 4'b0011, 1'b0);
    wait_valid(30);
    @(posedge clk_i); #1 stop_i = 1'b1;
    @(posedge clk_i); #1 stop_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("stop_rep_held", {31'd0, res_valid_o}, 1);
    @(posedge clk_i); #1 res_ready_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("stop_rep_idle", {31'd0, busy_o}, 0);
    check_eq("stop_rep_sb", exp_q.size(), 0);

    // Illegal starts and start masked by stop.
    start_run(0, 4'b0001, 1'b0);
    @(negedge clk_i);
    check_eq("err_win0", {31'd0, err_o}, 1);
    check_eq("err_win0_busy", {31'd0, busy_o}, 0);
    @(negedge clk_i);
    check_eq("err_win0_pulse", {31'd0, err_o}, 0);
    start_run(5, 4'b0000, 1'b0);
    @(negedge clk_i);
    check_eq("err_en0", {31'd0, err_o}, 1);
    check_eq("err_en0_busy", {31'd0, busy_o}, 0);
    @(negedge clk_i);
    check_eq("err_en0_pulse", {31'd0, err_o}, 0);
    @(posedge clk_i); #1;
    win_ticks_i = 5; ch_en_i = 4'b0001; start_i = 1'b1; stop_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0; stop_i = 1'b0;
    @(negedge clk_i);
    check_eq("startstop_busy", {31'd0, busy_o}, 0);
    check_eq("startstop_err", {31'd0, err_o}, 0);

    // Reset mid-window returns to reset values.
    dv_base = 4'b0100;
    start_run(10, 4'b0100, 1'b0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("pre_rst_ch_sel", {30'd0, ch_sel_o}, 2);
    @(posedge clk_i); #1 s_rst_i = 1'b1;
    @(posedge clk_i); #1 s_rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("midrst_busy", {31'd0, busy_o}, 0);
    check_eq("midrst_ch_sel", {30'd0, ch_sel_o}, 0);
    check_eq("midrst_valid", {31'd0, res_valid_o}, 0);

    // Overflow on the 8-bit result instance; 32-bit instance fits.
    dv_base = 4'b0001; res_ready_i = 1'b1;
    push_exp(2'd0, 32'd512);
    start_run(16, 4'b0001, 1'b0);
    begin
      int n = 0;
      do begin
        @(negedge clk_i);
        n++;
      end while (!o_res_valid && n < 50);
    end
    check_eq("ovf_valid", {31'd0, o_res_valid}, 1);
    check_eq("ovf_bits", {24'd0, o_res_bits}, 32'h0000_00FF);
    check_eq("ovf_flag", {31'd0, o_res_ovf}, 1);
    wait_idle(50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
